// File: rtl/store_write_buffer.sv
// Post-commit store write buffer: a FIFO of retired stores drained to memory in order,
// with a load-address conflict probe over the buffered words.
module store_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       store_req,
  input  logic [AW-1:0]              store_addr,
  input  logic [DW-1:0]              store_data,
  input  logic [1:0]                 store_size,
  output logic                       store_response,
  output logic                       mem_valid,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_data,
  output logic [3:0]                 mem_byte_en,
  input  logic                       mem_ack,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_conflict,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       misalign_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  logic [AW-3:0] waddr_mem [DEPTH];
  logic [DW-1:0] data_mem  [DEPTH];
  logic [3:0]    be_mem    [DEPTH];
  logic          mis_mem   [DEPTH];

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic          err_q;
  logic          pop, set_err;

  logic [3:0]    in_be;
  logic [DW-1:0] in_data;
  logic          in_mis;

  assign store_response = store_req && !reset && (count_q != CW'(DEPTH));
  assign count          = count_q;
  assign empty          = (count_q == '0);
  assign misalign_err   = err_q;

  always_comb begin
    in_be   = 4'b0000;
    in_data = store_data;
    in_mis  = 1'b0;
    unique case (store_size)
      2'd0: begin
        in_be   = 4'b0001 << store_addr[1:0];
        in_data = DW'(store_data[7:0]) << {store_addr[1:0], 3'b000};
      end
      2'd1: begin
        in_be   = 4'b0011 << {store_addr[1], 1'b0};
        in_data = DW'(store_data[15:0]) << {store_addr[1], 4'b0000};
        in_mis  = store_addr[0];
      end
      2'd2: begin
        in_be  = 4'b1111;
        in_mis = |store_addr[1:0];
      end
      default: in_mis = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    set_err     = 1'b0;
    mem_valid   = 1'b0;
    mem_addr    = '0;
    mem_data    = '0;
    mem_byte_en = 4'b0000;
    if (!reset) begin
      unique case (state_q)
        StIdle: ;
        StBusy: begin
          if (mis_mem[head_q]) begin
            pop     = 1'b1;
            set_err = 1'b1;
          end else begin
            mem_valid   = 1'b1;
            mem_addr    = {waddr_mem[head_q], 2'b00};
            mem_data    = data_mem[head_q];
            mem_byte_en = be_mem[head_q];
            pop         = mem_ack;
          end
        end
        default: ;
      endcase
    end
    count_d = count_q + CW'(store_response) - CW'(pop);
    // Entering BUSY on the edge that registers the first entry gives one-cycle drain latency.
    state_d = (count_d != '0) ? StBusy : StIdle;
  end

  always_comb begin
    logic [PW-1:0] off;
    off         = '0;
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if ((CW'(off) < count_q) && !mis_mem[i] && (waddr_mem[i] == ld_addr[AW-1:2])) begin
        ld_conflict = 1'b1;
      end
    end
    if (reset) ld_conflict = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      if (store_response) tail_q <= tail_q + PW'(1);
      if (pop)            head_q <= head_q + PW'(1);
      if (set_err)        err_q  <= 1'b1;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Storage is left uncleared; occupancy is defined by head/count alone.
  always_ff @(posedge clock) begin
    if (store_response) begin
      waddr_mem[tail_q] <= store_addr[AW-1:2];
      data_mem[tail_q]  <= in_data;
      be_mem[tail_q]    <= in_be;
      mis_mem[tail_q]   <= in_mis;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Randomized bench for store_write_buffer, checked against a queue-based model of the buffer.
module tb_store_write_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        store_req;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic [1:0]  store_size;
  logic        store_response;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_byte_en;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic [2:0]  count;
  logic        empty;
  logic        misalign_err;

  store_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .store_req      (store_req),
    .store_addr     (store_addr),
    .store_data     (store_data),
    .store_size     (store_size),
    .store_response (store_response),
    .mem_valid      (mem_valid),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_byte_en    (mem_byte_en),
    .mem_ack        (mem_ack),
    .ld_addr        (ld_addr),
    .ld_conflict    (ld_conflict),
    .count          (count),
    .empty          (empty),
    .misalign_err   (misalign_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          mis;
  } ent_t;

  ent_t q[$];
  bit   err_m;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t make_ent(input logic [31:0] a, input logic [31:0] d,
                                    input logic [1:0] sz);
    ent_t        e;
    int unsigned nbytes;
    logic [7:0]  lanes;
    nbytes  = 1 << sz;
    lanes   = 8'(((1 << nbytes) - 1) << a[1:0]);
    e.waddr = a[31:2];
    e.be    = lanes[3:0];
    e.data  = d << (8 * a[1:0]);
    e.mis   = (sz == 2'd3) || ((a & (nbytes - 1)) != 0);
    return e;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Drive one cycle, check all outputs mid-cycle, then advance the model at the edge.
  task automatic step(input bit req, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input bit ack, input logic [31:0] la, input bit rst);
    bit          exp_resp, exp_valid, exp_conf;
    logic [31:0] exp_addr, exp_data, msk;
    logic [3:0]  exp_be;
    store_req  = req;
    store_addr = a;
    store_data = d;
    store_size = sz;
    mem_ack    = ack;
    ld_addr    = la;
    reset      = rst;
    @(negedge clock);
    exp_resp  = req && !rst && (q.size() < 4);
    exp_valid = !rst && (q.size() > 0) && !q[0].mis;
    exp_addr  = exp_valid ? {q[0].waddr, 2'b00} : 32'h0;
    exp_be    = exp_valid ? q[0].be : 4'h0;
    exp_data  = exp_valid ? q[0].data : 32'h0;
    exp_conf  = 1'b0;
    if (!rst) foreach (q[i]) if (!q[i].mis && q[i].waddr == la[31:2]) exp_conf = 1'b1;
    msk = exp_valid ? lane_mask(exp_be) : 32'hffff_ffff;
    check("store_response", 64'(store_response), 64'(exp_resp));
    check("mem_valid", 64'(mem_valid), 64'(exp_valid));
    check("mem_addr", 64'(mem_addr), 64'(exp_addr));
    check("mem_byte_en", 64'(mem_byte_en), 64'(exp_be));
    check("mem_data", 64'(mem_data & msk), 64'(exp_data & msk));
    check("ld_conflict", 64'(ld_conflict), 64'(exp_conf));
    check("count", 64'(count), 64'(q.size()));
    check("empty", 64'(empty), 64'(q.size() == 0));
    check("misalign_err", 64'(misalign_err), 64'(err_m));
    if (rst) begin
      q.delete();
      err_m = 1'b0;
    end else begin
      if (q.size() > 0 && (q[0].mis || ack)) begin
        if (q[0].mis) err_m = 1'b1;
        void'(q.pop_front());
      end
      if (exp_resp) q.push_back(make_ent(a, d, sz));
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] a, la, amask;
    logic [1:0]  sz;
    bit          ack_bias;
    reset = 1'b1; store_req = 1'b0; store_addr = '0; store_data = '0; store_size = '0;
    mem_ack = 1'b0; ld_addr = '0;
    repeat (2) @(posedge clock);
    #1;
    step(1, 32'h100, 32'hdead_beef, 2, 1, 0, 1);
    // Single word store with ack tied high
    step(1, 32'h100, 32'hdead_beef, 2, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    // Byte and half lane placement
    step(1, 32'h203, 32'h0000_00ab, 0, 0, 0, 0);
    step(1, 32'h202, 32'h0000_1234, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    // Fill to capacity, then pop while the fifth is still requested
    for (int i = 0; i < 5; i++) step(1, 32'h400 + 4 * i, $urandom, 2, 0, 0, 0);
    step(1, 32'h414, 32'h5555_aaaa, 2, 1, 0, 0);
    step(1, 32'h414, 32'h5555_aaaa, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h414, 0);
    repeat (4) step(0, 0, 0, 0, 1, 32'h414, 0);
    // Load conflict probe
    step(1, 32'h300, 32'h1, 2, 0, 32'h302, 0);
    step(0, 0, 0, 0, 0, 32'h302, 0);
    step(0, 0, 0, 0, 0, 32'h304, 0);
    step(0, 0, 0, 0, 1, 32'h302, 0);
    step(0, 0, 0, 0, 0, 32'h302, 0);
    // Misaligned word is dropped, sticky error, then a normal store drains
    step(1, 32'h101, 32'h7, 2, 1, 32'h100, 0);
    step(1, 32'h104, 32'h8, 2, 1, 32'h104, 0);
    repeat (3) step(0, 0, 0, 0, 1, 0, 0);
    // Reset with entries pending
    for (int i = 0; i < 3; i++) step(1, 32'h500 + 4 * i, $urandom, 2, 0, 32'h500, 0);
    step(0, 0, 0, 0, 1, 32'h500, 1);
    step(0, 0, 0, 0, 1, 32'h500, 0);

    ack_bias = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (c % 100 == 0) ack_bias = ($urandom_range(0, 2) != 0);
      sz = 2'($urandom_range(0, 3));
      a  = 32'h100 + $urandom_range(0, 15);
      if (sz != 2'd3 && $urandom_range(0, 9) < 7) begin
        amask = (32'h1 << sz) - 1;
        a     = a & ~amask;
      end
      la = 32'h100 + $urandom_range(0, 15);
      step($urandom_range(0, 9) < 7, a, $urandom, sz,
           ack_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0),
           la, $urandom_range(0, 99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered committed stores (power of two, >=2).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, store data width.
REQ-004 SHALL have ports:
  clock  in  1  clock, rising-edge
  reset  in  1  reset, synchronous, active-high
  store_req  in  1  retire requests commit of SQ-head store
  store_addr  in  AW  store byte address
  store_data  in  DW  store data, right-aligned
  store_size  in  2  0=byte, 1=half, 2=word, 3=reserved
  store_response  out  1  store accepted this cycle
  mem_valid  out  1  write transaction presented to memory
  mem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
  mem_data  out  DW  data shifted into byte lanes
  mem_byte_en  out  4  byte-lane enables
  mem_ack  in  1  memory accepts presented write
  ld_addr  in  AW  load address probed for conflict
  ld_conflict  out  1  buffered store overlaps ld_addr word
  count  out  clog2(DEPTH+1)  occupied entries
  empty  out  1  count==0
  misalign_err  out  1  sticky: misaligned/reserved store dropped

Function
REQ-005 store_response SHALL be combinational: store_req && (count<DEPTH); no same-cycle dependence on mem_ack.
REQ-006 Accepted store SHALL be written at tail at next rising edge; tail increments modulo DEPTH.
REQ-007 Entry SHALL hold word address, lane-shifted data, byte_en, misaligned flag.
REQ-008 byte_en: size 0 -> 4'b0001<<addr[1:0]; size 1 -> 4'b0011<<{addr[1],1'b0}; size 2 -> 4'b1111.
REQ-009 Data shift: byte -> data[7:0] replicated/positioned at lane addr[1:0]; half -> data[15:0] at lane addr[1]*2; word unchanged.
REQ-010 Misaligned: size 1 with addr[0]=1, size 2 with addr[1:0]!=0, or size 3; entry flagged, still accepted.
REQ-011 Drain FSM SHALL have states IDLE, BUSY.
REQ-012 IDLE -> BUSY at edge when registered count>0; min enqueue-to-mem_valid latency 1 cycle.
REQ-013 In BUSY with unflagged head: mem_valid=1; mem_addr/mem_data/mem_byte_en = head fields, stable until mem_ack.
REQ-014 mem_valid && mem_ack SHALL pop head (head+1 mod DEPTH); stay BUSY if entries remain after pop, else IDLE.
REQ-015 In BUSY with flagged head: mem_valid=0, head popped that cycle, misalign_err set, next state per REQ-014.
REQ-016 Simultaneous enqueue and pop SHALL leave count unchanged; both pointers advance.
REQ-017 Enqueue when count==DEPTH SHALL NOT occur even if pop same cycle (store_response=0).
REQ-018 Drain order SHALL be strict FIFO; no merging or reordering.
REQ-019 ld_conflict SHALL be combinational: any valid, unflagged entry whose word address equals ld_addr[AW-1:2]; same-cycle incoming store excluded.
REQ-020 Entry being popped this cycle SHALL still count for ld_conflict in that cycle.
REQ-021 Branch mispredict/flush SHALL NOT affect contents; all entries are committed state.
REQ-022 count and empty SHALL reflect registered state only.
REQ-023 mem_addr/mem_data/mem_byte_en SHALL be 0 when mem_valid=0.

Reset
REQ-024 On reset: head=tail=0, count=0, empty=1, FSM=IDLE, misalign_err=0, mem_valid=0, ld_conflict=0.
REQ-025 Reset mid-transaction SHALL abandon in-flight write; mem_ack during reset ignored.
REQ-026 store_response SHALL be 0 while reset is asserted.
REQ-027 Entry storage need not be cleared; valid-qualified by pointers.

Verification
REQ-028 Single word store addr 0x100 data 0xDEADBEEF, mem_ack tied 1 -> response same cycle; next cycle mem_valid=1, addr 0x100, byte_en 1111; following cycle empty=1.
REQ-029 Byte store addr 0x203 data 0xAB -> mem_addr 0x200, byte_en 1000, mem_data[31:24]=0xAB; half at 0x202 data 0x1234 -> byte_en 1100, mem_data[31:16]=0x1234.
REQ-030 mem_ack held 0, issue 5 stores -> first 4 responded, 5th response=0, count=4; assert mem_ack one cycle with 5th still requested -> pop, 5th accepted next cycle, count stays 4.
REQ-031 Buffered store 0x300, ld_addr 0x302 -> ld_conflict=1; ld_addr 0x304 -> 0; after drain ack -> 0.
REQ-032 Word store at 0x101 -> accepted, never drives mem_valid, misalign_err=1 until reset; following valid store drains normally.
REQ-033 Reset with 3 entries and mem_valid pending -> next cycle count=0, mem_valid=0, empty=1.
